// File: rtl/fp_pkg.sv
// Shared FP datapath constants, leading-zero count width helper and count type.
package fp_pkg;

  localparam int unsigned MANT_W = 25;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned LZC_W = cnt_width(MANT_W);

  typedef logic [LZC_W-1:0] lzc_t;

endpackage

// File: rtl/lzc_core.sv
// Combinational leading-zero counter: a tree of 2-bit priority leaves over the
// input padded with zeros on the LSB side up to a power of two.
module lzc_core
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH = MANT_W,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  localparam int unsigned LVLS  = $clog2(WIDTH);
  localparam int unsigned PAD_W = 1 << LVLS;

  logic [PAD_W-1:0] pad;

  // LSB padding never moves the first set bit, so the count is unaffected.
  assign pad = PAD_W'(data) << (PAD_W - WIDTH);

  for (genvar g = 1; g <= LVLS; g++) begin : g_lvl
    localparam int unsigned N = PAD_W >> g;
    logic [N-1:0]    any;
    logic [LVLS-1:0] pos [N];
    for (genvar k = 0; k < N; k++) begin : g_node
      if (g == 1) begin : g_leaf
        assign any[k] = pad[2*k+1] | pad[2*k];
        assign pos[k] = LVLS'(!pad[2*k+1]);
      end else begin : g_merge
        // Upper half wins when it holds a one; otherwise skip its full span.
        assign any[k] = g_lvl[g-1].any[2*k+1] | g_lvl[g-1].any[2*k];
        assign pos[k] = g_lvl[g-1].any[2*k+1] ? g_lvl[g-1].pos[2*k+1]
                                              : (g_lvl[g-1].pos[2*k] | LVLS'(1 << (g - 1)));
      end
    end
  end

  assign zero = !g_lvl[LVLS].any[0];
  assign cnt  = zero ? CNT_W'(WIDTH) : CNT_W'(g_lvl[LVLS].pos[0]);

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined leading-zero count (stage 1) and normalising left shift
// (stage 2) with valid/ready on both sides and a pass-through tag.
module lzc_norm_pipe
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH = MANT_W,
  parameter int unsigned TAG_W = 8,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_lzc,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [TAG_W-1:0] s1_tag;
  logic [CNT_W-1:0] s1_lzc;
  logic             s1_zero;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [CNT_W-1:0] in_lzc;
  logic             in_zero;
  logic [WIDTH-1:0] shifted;

  lzc_core #(.WIDTH(WIDTH)) u_lzc (
    .data (in_data),
    .cnt  (in_lzc),
    .zero (in_zero)
  );

  // Ready propagates combinationally back through both registered stages.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = !rst && s1_adv;
  assign out_valid = s2_valid;

  // Log-depth barrel shift; for non-zero data the count never exceeds WIDTH-1.
  always_comb begin : barrel
    shifted = s1_data;
    for (int i = 0; i < SH_W; i++) begin
      if (s1_lzc[i]) shifted = shifted << (1 << i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
      s2_valid <= 1'b0;
      out_lzc  <= '0;
      out_norm <= '0;
      out_zero <= 1'b0;
      out_tag  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_tag  <= in_tag;
          s1_lzc  <= in_lzc;
          s1_zero <= in_zero;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_lzc  <= s1_zero ? CNT_W'(WIDTH) : s1_lzc;
          out_norm <= s1_zero ? '0 : shifted;
          out_zero <= s1_zero;
          out_tag  <= s1_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Self-checking bench for lzc_norm_pipe: directed vector table, walking one,
// backpressure, reset mid-flight and random stress against a scoreboard.
module tb_lzc_norm_pipe;
  import fp_pkg::*;

  localparam int unsigned W  = 25;
  localparam int unsigned TW = 8;
  localparam int N_STRESS    = 10000;
  localparam int N_VEC       = 10;

  typedef struct {
    lzc_t          lzc;
    logic [W-1:0]  norm;
    logic          zero;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    lzc_t          lzc;
    logic [W-1:0]  norm;
    logic          zero;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  lzc_t          out_lzc;
  logic [W-1:0]  out_norm;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  exp_t        cur_exp;
  logic        held_v = 1'b0;
  logic [63:0] held;
  bit          chk_lat = 1'b0;
  vec_t        vecs[N_VEC];

  lzc_norm_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lzc   (out_lzc),
    .out_norm  (out_norm),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, required none (cycle %0d)", name, cyc);
  endfunction

  function automatic logic [63:0] pack_out();
    return 64'({out_lzc, out_norm, out_zero, out_tag});
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    return 64'({e.lzc, e.norm, e.zero, e.tag});
  endfunction

  // Reference: scan from the MSB for the first one.
  function automatic exp_t model(input logic [W-1:0] d, input logic [TW-1:0] t);
    exp_t e;
    e.lzc  = lzc_t'(W);
    e.zero = 1'b1;
    e.norm = '0;
    e.tag  = t;
    e.acc  = 0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (d[i]) begin
        e.lzc  = lzc_t'(int'(W) - 1 - i);
        e.zero = 1'b0;
        e.norm = d << (int'(W) - 1 - i);
        break;
      end
    end
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.lzc  = v.lzc;
    e.norm = v.norm;
    e.zero = v.zero;
    e.tag  = v.tag;
    e.acc  = 0;
    return e;
  endfunction

  // Scoreboard and hold-stability monitor, evaluated at the falling edge.
  task automatic monitor();
    exp_t e;
    if (rst) begin
      sb.delete();
      held_v = 1'b0;
      return;
    end
    if (held_v) chk("hold", pack_out() | (64'(out_valid) << 40), held | (64'd1 << 40));
    held_v = out_valid && !out_ready;
    held   = pack_out();
    if (out_valid && out_ready) begin
      if (sb.size() == 0) fail("spurious_out");
      else begin
        e = sb.pop_front();
        chk("result", pack_out(), pack_exp(e));
        if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'd2);
      end
    end
    if (in_valid && in_ready) begin
      e     = cur_exp;
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input exp_t e, input logic [W-1:0] d, input bit want_ready);
    int budget = 100;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = e.tag;
    cur_exp  = e;
    while (!done) begin
      to_neg();
      if (want_ready) chk("in_ready", 64'(in_ready), 64'd1);
      done = in_ready;
      to_pos();
      budget--;
      if (!done && budget == 0) begin
        fail("send_timeout");
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 100;
    while ((sb.size() != 0 || out_valid) && budget > 0) begin
      to_neg();
      to_pos();
      budget--;
    end
    chk("drain_left", 64'(sb.size()) + 64'(out_valid), 64'd0);
  endtask

  initial begin
    exp_t          e;
    exp_t          bp_a;
    exp_t          bp_b;
    exp_t          bp_c;
    logic [W-1:0]  one;
    logic [W-1:0]  d;
    int            sent;
    int            budget;
    bit            acc;

    vecs[0] = '{25'h1000000, 8'h11, 5'd0,  25'h1000000, 1'b0};
    vecs[1] = '{25'h0000001, 8'h12, 5'd24, 25'h1000000, 1'b0};
    vecs[2] = '{25'h0000000, 8'h13, 5'd25, 25'h0000000, 1'b1};
    vecs[3] = '{25'h00A5F3C, 8'h14, 5'd5,  25'h14BE780, 1'b0};
    vecs[4] = '{25'h1FFFFFF, 8'h15, 5'd0,  25'h1FFFFFF, 1'b0};
    vecs[5] = '{25'h0800000, 8'h16, 5'd1,  25'h1000000, 1'b0};
    vecs[6] = '{25'h0000003, 8'h17, 5'd23, 25'h1800000, 1'b0};
    vecs[7] = '{25'h0012345, 8'h18, 5'd8,  25'h1234500, 1'b0};
    vecs[8] = '{25'h0000002, 8'h19, 5'd23, 25'h1000000, 1'b0};
    vecs[9] = '{25'h0400001, 8'h1A, 5'd2,  25'h1000004, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    cur_exp = model('0, '0);
    to_pos();
    to_pos();
    to_neg();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", pack_out(), 64'd0);
    to_pos();
    rst = 1'b0;
    to_neg();
    chk("ready_after_rst", 64'(in_ready), 64'd1);
    to_pos();

    // Directed single beats with fixed two-cycle latency.
    chk_lat = 1'b1;
    for (int i = 0; i < N_VEC; i++) begin
      send(from_vec(vecs[i]), vecs[i].data, 1'b1);
      wait_idle();
    end

    // Walking one at full throughput.
    one = 1;
    for (int k = int'(W) - 1; k >= 0; k--) begin
      e.lzc  = lzc_t'(int'(W) - 1 - k);
      e.norm = 25'h1000000;
      e.zero = 1'b0;
      e.tag  = 8'(8'h40 + 24 - k);
      e.acc  = 0;
      send(e, one << k, 1'b1);
    end
    wait_idle();
    chk_lat = 1'b0;

    // Backpressure: two beats fill the pipe, the third waits for release.
    bp_a = model(25'h0040000, 8'hA0);
    bp_b = model(25'h0000155, 8'hA1);
    bp_c = model(25'h1555555, 8'hA2);
    chk("bp_a_model", pack_exp(bp_a), pack_exp('{5'd6, 25'h1000000, 1'b0, 8'hA0, 0}));
    chk("bp_b_model", pack_exp(bp_b), pack_exp('{5'd16, 25'h1550000, 1'b0, 8'hA1, 0}));
    out_ready = 1'b0;
    send(bp_a, 25'h0040000, 1'b0);
    send(bp_b, 25'h0000155, 1'b0);
    in_valid = 1'b1; in_data = 25'h1555555; in_tag = bp_c.tag; cur_exp = bp_c;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out", pack_out(), pack_exp(bp_a));
      to_pos();
    end
    out_ready = 1'b1;
    to_neg();
    chk("release_ready", 64'(in_ready), 64'd1);
    to_pos();
    in_valid = 1'b0;
    wait_idle();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(model(25'h0001000, 8'hB0), 25'h0001000, 1'b0);
    send(model(25'h0000000, 8'hB1), 25'h0000000, 1'b0);
    rst = 1'b1;
    to_neg();
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    to_pos();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      to_pos();
    end
    chk_lat = 1'b1;
    send(from_vec(vecs[7]), vecs[7].data, 1'b1);
    wait_idle();
    chk_lat = 1'b0;

    // Random valid/ready stress.
    sent = 0;
    budget = 60000;
    while (sent < N_STRESS && budget > 0) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        d        = W'($urandom) >> $urandom_range(0, W);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = TW'(sent);
        cur_exp  = model(d, TW'(sent));
      end
      to_neg();
      acc = in_valid && in_ready;
      if (acc) sent++;
      to_pos();
      if (acc) in_valid = 1'b0;
      budget--;
    end
    chk("stress_sent", 64'(sent), 64'(N_STRESS));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
